// File: rtl/cf_uart_rx_engine.sv
// cf_uart_rx_engine: receive-side frame engine of the CF_UART core.
// Oversamples rx at SC (8) samples per bit from an internal prescaler.
// Deframes 5-9 data bits with optional parity and one or two stop bits.
// Emits a one-clock FIFO write strobe with per-frame parity/frame/break/match
// flags, plus a one-clock idle-timeout pulse.
// Optional feature macro: CF_UART_RX_GLITCH_FILTER_EN. When defined:
//   - each bit decision is a 2-of-3 majority of the ticks 3, 4 and 5 samples;
//   - a start edge needs two consecutive low samples.
// Otherwise bits are single samples at tick 4.

module cf_uart_rx_engine #(
    parameter int MDW = 9,
    parameter int SC  = 8,
    parameter int PRW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [PRW-1:0] prescale,
    input  logic [3:0]     data_size,
    input  logic           stop2,
    input  logic [2:0]     parity,
    input  logic [5:0]     timeout_bits,
    input  logic [MDW-1:0] match_data,
    input  logic           rx,
    output logic [MDW-1:0] data_out,
    output logic           wr,
    output logic           parity_err,
    output logic           frame_err,
    output logic           break_det,
    output logic           match,
    output logic           rx_timeout
);
    localparam int SCW = $clog2(SC);
    localparam logic [SCW-1:0] BIT_LAST = SCW'(SC - 1);
`ifdef CF_UART_RX_GLITCH_FILTER_EN
    // Decision moves to tick 5 so the third majority sample exists.
    localparam logic [SCW-1:0] START_LAST = SCW'(SC / 2);
`else
    localparam logic [SCW-1:0] START_LAST = SCW'(SC / 2 - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t         state;
    logic           rx_s1, rx_s2, rx_d1;
    logic [PRW-1:0] pcnt, presc_q;
    logic           tick, decide, fall, bit_val;
    logic [SCW-1:0] tick_cnt;
    logic [3:0]     bit_idx, nbits;
    logic [MDW-1:0] data_sr;
    logic           all_zero, stop_err, par_err_q;
    logic           par_en, par_exp;
    logic           to_armed;
    logic [SCW-1:0] to_ticks;
    logic [5:0]     to_bits;

    // Two-flop synchronizer plus one history flop for edge detection.
    // NOTE: these reset to 1 (idle line level) so leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d1 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d1 <= rx_s2;
        end
    end

`ifdef CF_UART_RX_GLITCH_FILTER_EN
    logic       rx_d2;
    logic [1:0] hist;

    // Extra edge history and the two previous tick samples for the majority vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_d2 <= 1'b1;
            hist  <= 2'b11;
        end else begin
            rx_d2 <= rx_d1;
            if (!en)
                hist <= 2'b11;
            else if (tick)
                hist <= {hist[0], rx_s2};
        end
    end

    assign fall    = rx_d2 & ~rx_d1 & ~rx_s2;
    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s2) | (hist[0] & rx_s2);
`else
    assign fall    = rx_d1 & ~rx_s2;
    assign bit_val = rx_s2;
`endif

    // Free-running sample prescaler; the period is reloaded only at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= '0;
            presc_q <= '0;
        end else if (!en || pcnt == presc_q) begin
            pcnt    <= '0;
            presc_q <= prescale;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign tick   = en && (pcnt == presc_q);
    assign decide = tick && (tick_cnt == ((state == S_START) ? START_LAST : BIT_LAST));
    assign nbits  = (data_size >= 4'd5 && data_size <= 4'd9) ? data_size : 4'd8;

    // Parity enable and the bit value the line should carry for this data word.
    // NOTE: both outputs get a default first so no path through the case infers a latch.
    always_comb begin
        par_en  = 1'b1;
        par_exp = 1'b0;
        case (parity)
            3'b001:  par_exp = ~^data_sr;
            3'b010:  par_exp = ^data_sr;
            3'b100:  par_exp = 1'b0;
            3'b101:  par_exp = 1'b1;
            default: par_en  = 1'b0;
        endcase
    end

    // Frame FSM with registered strobes, flags and the idle-timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            data_sr    <= '0;
            all_zero   <= 1'b0;
            stop_err   <= 1'b0;
            par_err_q  <= 1'b0;
            data_out   <= '0;
            wr         <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            match      <= 1'b0;
            rx_timeout <= 1'b0;
            to_armed   <= 1'b0;
            to_ticks   <= '0;
            to_bits    <= '0;
        end else begin
            // NOTE: pulses default low here; a later assignment in this block overrides.
            wr         <= 1'b0;
            rx_timeout <= 1'b0;
            if (!en) begin
                state    <= S_IDLE;
                tick_cnt <= '0;
                bit_idx  <= '0;
                to_armed <= 1'b0;
                to_ticks <= '0;
                to_bits  <= '0;
            end else begin
                if (tick && state != S_IDLE)
                    tick_cnt <= decide ? '0 : tick_cnt + 1'b1;
                case (state)
                    S_IDLE: begin
                        if (fall) begin
                            state     <= S_START;
                            tick_cnt  <= '0;
                            bit_idx   <= '0;
                            data_sr   <= '0;
                            all_zero  <= 1'b1;
                            stop_err  <= 1'b0;
                            par_err_q <= 1'b0;
                            to_armed  <= 1'b0;
                            to_ticks  <= '0;
                            to_bits   <= '0;
                        end else if (to_armed && tick) begin
                            if (to_ticks == BIT_LAST) begin
                                to_ticks <= '0;
                                to_bits  <= to_bits + 6'd1;
                                if (timeout_bits != 6'd0 && to_bits + 6'd1 == timeout_bits) begin
                                    rx_timeout <= 1'b1;
                                    to_armed   <= 1'b0;
                                end
                            end else begin
                                to_ticks <= to_ticks + 1'b1;
                            end
                        end
                    end
                    S_START: begin
                        if (decide)
                            state <= bit_val ? S_IDLE : S_DATA;
                    end
                    S_DATA: begin
                        if (decide) begin
                            data_sr[bit_idx] <= bit_val;
                            if (bit_val)
                                all_zero <= 1'b0;
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx == nbits - 4'd1)
                                state <= par_en ? S_PARITY : S_STOP1;
                        end
                    end
                    S_PARITY: begin
                        if (decide) begin
                            par_err_q <= (bit_val != par_exp);
                            if (bit_val)
                                all_zero <= 1'b0;
                            state <= S_STOP1;
                        end
                    end
                    S_STOP1: begin
                        if (decide) begin
                            if (stop2) begin
                                stop_err <= ~bit_val;
                                all_zero <= all_zero & ~bit_val;
                                state    <= S_STOP2;
                            end else begin
                                wr         <= 1'b1;
                                data_out   <= data_sr;
                                parity_err <= par_err_q;
                                frame_err  <= ~bit_val;
                                break_det  <= all_zero & ~bit_val;
                                match      <= (data_sr == match_data);
                                to_armed   <= 1'b1;
                                to_ticks   <= '0;
                                to_bits    <= '0;
                                state      <= S_IDLE;
                            end
                        end
                    end
                    S_STOP2: begin
                        if (decide) begin
                            wr         <= 1'b1;
                            data_out   <= data_sr;
                            parity_err <= par_err_q;
                            frame_err  <= stop_err | ~bit_val;
                            break_det  <= all_zero;
                            match      <= (data_sr == match_data);
                            to_armed   <= 1'b1;
                            to_ticks   <= '0;
                            to_bits    <= '0;
                            state      <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cf_uart_rx_engine.sv
// Testbench for cf_uart_rx_engine: directed scenarios plus randomized frames.
// A reference model built from framing rules predicts every write.
module tb_cf_uart_rx_engine;
    localparam int MDW = 9;
    localparam int SC  = 8;
    localparam int PRW = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [PRW-1:0] prescale = 16'd10;
    logic [3:0]     data_size = 4'd8;
    logic           stop2 = 1'b0;
    logic [2:0]     parity = 3'b000;
    logic [5:0]     timeout_bits = 6'd0;
    logic [MDW-1:0] match_data = '0;
    logic           rx = 1'b1;
    logic [MDW-1:0] data_out;
    logic           wr, parity_err, frame_err, break_det, match, rx_timeout;

    cf_uart_rx_engine #(.MDW(MDW), .SC(SC), .PRW(PRW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale),
        .data_size(data_size), .stop2(stop2), .parity(parity),
        .timeout_bits(timeout_bits), .match_data(match_data), .rx(rx),
        .data_out(data_out), .wr(wr), .parity_err(parity_err),
        .frame_err(frame_err), .break_det(break_det), .match(match),
        .rx_timeout(rx_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MDW-1:0] data;
        logic           pe, fe, bd, m;
        int             cyc;
    } wr_ev_t;

    wr_ev_t wr_q[$];
    int cyc = 0, to_cnt = 0, to_cyc = 0, start_cyc = 0;
    int n_vec = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write strobe and timeout pulse away from the active edge.
    always @(negedge clk) begin
        wr_ev_t ev;
        if (wr) begin
            ev.data = data_out; ev.pe = parity_err; ev.fe = frame_err;
            ev.bd = break_det; ev.m = match; ev.cyc = cyc;
            wr_q.push_back(ev);
        end
        if (rx_timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model helpers taken straight from the framing rules.
    function automatic int eff_bits(input logic [3:0] ds);
        return (ds >= 4'd5 && ds <= 4'd9) ? int'(ds) : 8;
    endfunction

    function automatic bit par_on(input logic [2:0] mode);
        return mode == 3'b001 || mode == 3'b010 || mode == 3'b100 || mode == 3'b101;
    endfunction

    function automatic logic ref_parity(input logic [2:0] mode, input logic [MDW-1:0] d);
        int ones = $countones(d);
        case (mode)
            3'b001:  return (ones % 2) == 0;
            3'b010:  return (ones % 2) == 1;
            3'b101:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [MDW-1:0] mask_bits(input logic [MDW-1:0] d, input int nb);
        logic [MDW-1:0] r = '0;
        for (int i = 0; i < nb; i++) r[i] = d[i];
        return r;
    endfunction

    task automatic drive_line(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [MDW-1:0] d, input logic pbit, input logic s1v,
                              input logic s2v, input int idle_bits);
        int bc = (int'(prescale) + 1) * SC;
        int nb = eff_bits(data_size);
        start_cyc = cyc;
        drive_line(1'b0, bc);
        for (int i = 0; i < nb; i++) drive_line(d[i], bc);
        if (par_on(parity)) drive_line(pbit, bc);
        drive_line(s1v, bc);
        if (stop2) drive_line(s2v, bc);
        drive_line(1'b1, idle_bits * bc);
    endtask

    task automatic check_frame(input string tag, input logic [MDW-1:0] d, input logic pbit,
                               input logic s1v, input logic s2v, output int wcyc);
        int nb = eff_bits(data_size);
        logic [MDW-1:0] ed = mask_bits(d, nb);
        logic epe = par_on(parity) && (pbit != ref_parity(parity, ed));
        logic efe = !s1v || (stop2 && !s2v);
        logic ebd = (ed == '0) && (!par_on(parity) || !pbit) && !s1v;
        wr_ev_t ev;
        wcyc = -1;
        check({tag, " wr_count"}, wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            ev = wr_q.pop_front();
            wcyc = ev.cyc;
            check({tag, " data_out"}, ev.data, ed);
            check({tag, " parity_err"}, ev.pe, epe);
            check({tag, " frame_err"}, ev.fe, efe);
            check({tag, " break_det"}, ev.bd, ebd);
            check({tag, " match"}, ev.m, ed == match_data);
        end
        wr_q.delete();
    endtask

    initial begin
        int bc, wcyc, lat, dly;
        logic [MDW-1:0] d;
        logic pb, s1, s2;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst wr", wr, 0);
        check("rst data_out", data_out, 0);
        check("rst flags", {parity_err, frame_err, break_det, match}, 0);
        check("rst rx_timeout", rx_timeout, 0);
        rst_n = 1'b1;
        en = 1'b1;
        drive_line(1'b1, 40);
        check("post-rst no wr", wr_q.size(), 0);

        // 8N1 0xA5 at prescale 10 with latency window
        send_frame(9'h0A5, 1'b0, 1'b1, 1'b1, 2);
        check_frame("a5", 9'h0A5, 1'b0, 1'b1, 1'b1, wcyc);
        lat = wcyc - start_cyc;
        check("a5 latency_in_822_850", (lat >= 822 && lat <= 850), 1);

        // Stick-1 parity, two stop bits, prescale 21
        prescale = 16'd21; parity = 3'b101; stop2 = 1'b1;
        drive_line(1'b1, 30);
        send_frame(9'h0C3, 1'b1, 1'b1, 1'b1, 1);
        check_frame("c3", 9'h0C3, 1'b1, 1'b1, 1'b1, wcyc);
        send_frame(9'h091, 1'b1, 1'b1, 1'b1, 1);
        check_frame("91", 9'h091, 1'b1, 1'b1, 1'b1, wcyc);
        send_frame(9'h0C3, 1'b0, 1'b1, 1'b1, 1);
        check_frame("c3 bad parity", 9'h0C3, 1'b0, 1'b1, 1'b1, wcyc);

        // Break: line low 12 bit-times in 8N1
        prescale = 16'd10; parity = 3'b000; stop2 = 1'b0;
        drive_line(1'b1, 30);
        bc = (int'(prescale) + 1) * SC;
        drive_line(1'b0, 12 * bc);
        drive_line(1'b1, 2 * bc);
        check_frame("break", 9'h000, 1'b0, 1'b0, 1'b0, wcyc);

        // Short low glitch on idle line is a false start
        drive_line(1'b0, 2 * (int'(prescale) + 1));
        drive_line(1'b1, 3 * bc);
        check("glitch no wr", wr_q.size(), 0);

        // Match compare
        match_data = 9'h05A;
        send_frame(9'h05A, 1'b0, 1'b1, 1'b1, 1);
        check_frame("match 5a", 9'h05A, 1'b0, 1'b1, 1'b1, wcyc);
        send_frame(9'h05B, 1'b0, 1'b1, 1'b1, 1);
        check_frame("match 5b", 9'h05B, 1'b0, 1'b1, 1'b1, wcyc);

        // Idle timeout of 4 bit-times after a frame
        timeout_bits = 6'd4;
        drive_line(1'b1, 2 * bc);
        to_cnt = 0;
        send_frame(9'h033, 1'b0, 1'b1, 1'b1, 8);
        check_frame("timeout frame", 9'h033, 1'b0, 1'b1, 1'b1, wcyc);
        check("timeout pulse count", to_cnt, 1);
        dly = to_cyc - wcyc;
        check("timeout delay_in_4bits", (dly >= 4 * bc - (bc / SC) && dly <= 4 * bc + (bc / SC)), 1);

        // Drop enable mid-frame: frame discarded, next one received
        timeout_bits = 6'd0;
        drive_line(1'b0, bc);
        drive_line(1'b1, bc);
        drive_line(1'b0, bc);
        drive_line(1'b1, bc / 2);
        en = 1'b0;
        drive_line(1'b1, 30);
        en = 1'b1;
        drive_line(1'b1, 3 * bc);
        check("en drop no wr", wr_q.size(), 0);
        send_frame(9'h0E7, 1'b0, 1'b1, 1'b1, 1);
        check_frame("after en drop", 9'h0E7, 1'b0, 1'b1, 1'b1, wcyc);

        // Randomized frames against the model
        for (int k = 0; k < 16; k++) begin
            prescale  = PRW'($urandom_range(3, 12));
            data_size = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(5, 9));
            parity    = 3'($urandom_range(0, 7));
            stop2     = 1'($urandom_range(0, 1));
            d         = MDW'($urandom);
            if ($urandom_range(0, 5) == 0) d = '0;
            pb        = 1'($urandom_range(0, 1));
            s1        = ($urandom_range(0, 5) != 0);
            s2        = ($urandom_range(0, 5) != 0);
            match_data = ($urandom_range(0, 2) == 0) ? mask_bits(d, eff_bits(data_size))
                                                     : MDW'($urandom);
            drive_line(1'b1, 20);
            send_frame(d, pb, s1, s2, $urandom_range(1, 2));
            check_frame($sformatf("rand%0d", k), d, pb, s1, s2, wcyc);
        end

        // Asynchronous reset mid-frame clears outputs and drops the frame
        prescale = 16'd10; data_size = 4'd8; parity = 3'b000; stop2 = 1'b0;
        drive_line(1'b1, 30);
        bc = (int'(prescale) + 1) * SC;
        drive_line(1'b0, bc);
        drive_line(1'b1, bc);
        rst_n = 1'b0;
        #1;
        check("midrst data_out", data_out, 0);
        check("midrst flags", {wr, parity_err, frame_err, break_det, match}, 0);
        drive_line(1'b1, 5);
        rst_n = 1'b1;
        drive_line(1'b1, 3 * bc);
        check("midrst no wr", wr_q.size(), 0);
        send_frame(9'h0A5, 1'b0, 1'b1, 1'b1, 1);
        check_frame("after midrst", 9'h0A5, 1'b0, 1'b1, 1'b1, wcyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
